// File: rtl/config_loader_pkg.sv
// Purpose: shared types and helpers for the configuration chain loader.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package config_loader_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of words needed to cover num bits with den-bit words
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/config_loader_piso.sv
// Purpose: WIDTH-bit parallel-in serial-out register, LSB leaves first.
// Latency: load visible on dout the cycle after load; one bit per shift cycle.
// Backpressure: none; load has priority over shift.
// Ports: clk/rst, load + din (parallel capture), shift (>>1), dout (bit 0).
module config_loader_piso #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr >> 1;
        end
    end

    assign dout = sr[0];

endmodule

// File: rtl/config_loader.sv
// Purpose: serialise config words LSB-first into the shift chain and capture readback words.
// Latency: frame = CHAIN_LENGTH + words + 2 cycles from start to done with words always offered.
// Backpressure: word_ready only in LOAD; readback_valid is a pulse with no backpressure.
// Ports: start/busy/done frame control; word_valid/word_ready/word_data input words;
//        shift_enable/shift_in/chain_out chain interface; readback_valid/readback_data captured words.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int WORD_WIDTH   = 32,
    parameter int CHAIN_LENGTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic [WORD_WIDTH-1:0] word_data,
    output logic                  shift_enable,
    output logic                  shift_in,
    input  logic                  chain_out,
    output logic [WORD_WIDTH-1:0] readback_data,
    output logic                  readback_valid
);

    localparam int CNT_WIDTH = $clog2(CHAIN_LENGTH + 1);
    localparam int IDX_WIDTH = $clog2(WORD_WIDTH + 1);

    state_t                state;
    logic [CNT_WIDTH-1:0]  total;
    logic [IDX_WIDTH-1:0]  bit_idx;
    logic [IDX_WIDTH-1:0]  bit_cnt;
    logic [IDX_WIDTH-1:0]  word_bits;
    logic [WORD_WIDTH-1:0] capture;
    logic [WORD_WIDTH-1:0] capture_nxt;
    logic                  accept;
    logic                  last_bit;
    logic                  piso_bit;
    int                    remaining;

    assign accept   = word_valid && word_ready;
    assign last_bit = (state == ST_SHIFT) && ((bit_idx + IDX_WIDTH'(1)) == bit_cnt);

    // The final word of a frame may be shorter than WORD_WIDTH
    always_comb begin
        remaining = CHAIN_LENGTH - int'(total);
        word_bits = IDX_WIDTH'(WORD_WIDTH);
        if (remaining < WORD_WIDTH) begin
            word_bits = IDX_WIDTH'(remaining);
        end
    end

    // Capture register with the current chain_out bit merged in, so the
    // readback word includes the bit sampled on the word's last edge
    always_comb begin
        capture_nxt = capture;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (i == int'(bit_idx)) begin
                capture_nxt[i] = chain_out;
            end
        end
    end

    config_loader_piso #(
        .WIDTH (WORD_WIDTH)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (state == ST_SHIFT),
        .din   (word_data),
        .dout  (piso_bit)
    );

    // Leftover bits of a truncated last word must never reach the chain
    assign shift_in = piso_bit && shift_enable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            total          <= '0;
            bit_idx        <= '0;
            bit_cnt        <= '0;
            capture        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            word_ready     <= 1'b0;
            shift_enable   <= 1'b0;
            readback_data  <= '0;
            readback_valid <= 1'b0;
        end else begin
            done           <= 1'b0;
            readback_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_LOAD;
                        total      <= '0;
                        busy       <= 1'b1;
                        word_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        state        <= ST_SHIFT;
                        bit_cnt      <= word_bits;
                        bit_idx      <= '0;
                        capture      <= '0;
                        word_ready   <= 1'b0;
                        shift_enable <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    total   <= total + CNT_WIDTH'(1);
                    bit_idx <= bit_idx + IDX_WIDTH'(1);
                    capture <= capture_nxt;
                    if (last_bit) begin
                        readback_data  <= capture_nxt;
                        readback_valid <= 1'b1;
                        shift_enable   <= 1'b0;
                        if ((total + CNT_WIDTH'(1)) == CNT_WIDTH'(CHAIN_LENGTH)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= ST_LOAD;
                            word_ready <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Purpose: randomized self-checking bench for config_loader with a behavioural chain model.
// Latency: n/a.
// Backpressure: word_valid withheld / offered outside LOAD to exercise the handshake.
module tb_config_loader;
    import config_loader_pkg::*;

    localparam int WW = 4;
    localparam int L0 = 8;
    localparam int L1 = 6;

    logic clk;
    logic rst;
    logic [1:0] start;
    logic [1:0] word_valid;
    logic [1:0][WW-1:0] word_data;
    wire  [1:0] busy, done, word_ready, shift_enable, shift_in, readback_valid, chain_out;
    wire  [1:0][WW-1:0] readback_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] last_stream;
    logic [3:0] last_rb0, last_rb1;

    // Behavioural chains: serial input enters at index 0, leaves at the top
    logic [L0-1:0] chain0 = 8'h3C;
    logic [L1-1:0] chain1 = 6'h2D;

    always @(posedge clk) begin
        if (shift_enable[0]) chain0 <= {chain0[L0-2:0], shift_in[0]};
        if (shift_enable[1]) chain1 <= {chain1[L1-2:0], shift_in[1]};
    end

    assign chain_out[0] = chain0[L0-1];
    assign chain_out[1] = chain1[L1-1];

    config_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(L0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .word_valid(word_valid[0]), .word_ready(word_ready[0]), .word_data(word_data[0]),
        .shift_enable(shift_enable[0]), .shift_in(shift_in[0]), .chain_out(chain_out[0]),
        .readback_data(readback_data[0]), .readback_valid(readback_valid[0])
    );

    config_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(L1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .word_valid(word_valid[1]), .word_ready(word_ready[1]), .word_data(word_data[1]),
        .shift_enable(shift_enable[1]), .shift_in(shift_in[1]), .chain_out(chain_out[1]),
        .readback_data(readback_data[1]), .readback_valid(readback_valid[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] chain_get(input int d);
        return (d == 0) ? chain0 : {2'b00, chain1};
    endfunction

    task automatic check_quiet(input int d, input string tag);
        check_eq({tag, "_busy"}, busy[d], 0);
        check_eq({tag, "_done"}, done[d], 0);
        check_eq({tag, "_ready"}, word_ready[d], 0);
        check_eq({tag, "_se"}, shift_enable[d], 0);
        check_eq({tag, "_sin"}, shift_in[d], 0);
        check_eq({tag, "_rbv"}, readback_valid[d], 0);
        check_eq({tag, "_rbd"}, readback_data[d], 0);
    endtask

    // One frame of two words; gap = cycles word_valid is withheld before the first word;
    // poke = randomly pulse start while busy (must be ignored)
    task automatic run_frame(input int d, input logic [3:0] w0, input logic [3:0] w1,
                             input int gap, input bit poke);
        int len, nw, cyc, se_cnt, stalls, widx, lat, dones, k;
        logic [7:0] old, exp_stream, exp_chain, got_stream;
        logic [3:0] wq [2];
        logic [3:0] exp_rb [2];
        logic [3:0] rb_q [$];
        bit seen;

        len = (d == 0) ? L0 : L1;
        nw  = ceil_div(len, WW);
        wq[0] = w0;
        wq[1] = w1;
        old = chain_get(d);
        exp_stream = '0;
        exp_chain  = '0;
        for (int b = 0; b < len; b++) begin
            exp_stream[b]         = wq[b / WW][b % WW];
            exp_chain[len - 1 - b] = wq[b / WW][b % WW];
        end
        // Previous contents come out deepest-first, grouped into words
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < WW; i++) begin
                k = j * WW + i;
                exp_rb[j][i] = (k < len) ? old[len - 1 - k] : 1'b0;
            end
        end

        @(negedge clk);
        start[d] = 1'b1;
        cyc = 1; se_cnt = 0; stalls = 0; widx = 0; lat = 0; seen = 1'b0;
        got_stream = '0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start[d] = poke && busy[d] && ($urandom_range(3) == 0);
            if (shift_enable[d]) begin
                if (se_cnt < 8) got_stream[se_cnt] = shift_in[d];
                se_cnt++;
            end
            if (readback_valid[d]) rb_q.push_back(readback_data[d]);
            if (done[d]) begin
                seen = 1'b1;
                lat  = cyc;
            end
            if (word_ready[d] && widx == 0 && stalls < gap) begin
                check_eq("stall_se", shift_enable[d], 0);
                word_valid[d] = 1'b0;
                word_data[d]  = 4'($urandom);
                stalls++;
            end else if (word_ready[d] && widx < 2) begin
                word_valid[d] = 1'b1;
                word_data[d]  = wq[widx];
                widx++;
            end else begin
                // Offers outside LOAD must not be taken
                word_valid[d] = 1'($urandom_range(1));
                word_data[d]  = 4'($urandom);
            end
        end
        start[d] = 1'b0;
        word_valid[d] = 1'b0;
        check_eq("done_seen", seen, 1);
        check_eq("latency", lat, len + nw + 2 + stalls);
        check_eq("se_cycles", se_cnt, len);
        check_eq("stream", got_stream, exp_stream);
        check_eq("rb_count", rb_q.size(), nw);
        if (rb_q.size() >= 2) begin
            check_eq("rb_word0", rb_q[0], exp_rb[0]);
            check_eq("rb_word1", rb_q[1], exp_rb[1]);
            last_rb0 = rb_q[0];
            last_rb1 = rb_q[1];
        end
        dones = 0;
        @(negedge clk);
        check_eq("busy_after_done", busy[d], 0);
        check_eq("ready_after_done", word_ready[d], 0);
        repeat (3) begin
            if (done[d]) dones++;
            @(negedge clk);
        end
        check_eq("extra_done", dones, 0);
        check_eq("chain", chain_get(d), exp_chain);
        last_stream = got_stream;
    endtask

    task automatic reset_mid_shift();
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        word_valid[0] = 1'b1;
        word_data[0]  = 4'($urandom);
        @(negedge clk);
        word_valid[0] = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_se", shift_enable[0], 1);
        #2 rst = 1'b1;
        #1 check_quiet(0, "mid_rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = '0;
        word_valid = '0;
        word_data = '0;
        repeat (3) @(negedge clk);
        check_quiet(0, "rst_a");
        check_quiet(1, "rst_b");
        rst = 1'b0;

        run_frame(0, 4'hA, 4'h5, 0, 1'b0);
        check_eq("tp_stream", last_stream, 8'b01011010);
        run_frame(0, 4'h0, 4'h0, 0, 1'b0);
        check_eq("tp_reload_rb0", last_rb0, 4'hA);
        check_eq("tp_reload_rb1", last_rb1, 4'h5);
        run_frame(0, 4'($urandom), 4'($urandom), 5, 1'b0);

        run_frame(1, 4'hF, 4'hF, 0, 1'b0);
        run_frame(1, 4'hF, 4'hF, 0, 1'b0);
        check_eq("tp_partial_rb1", last_rb1, 4'h3);

        reset_mid_shift();
        run_frame(0, 4'($urandom), 4'($urandom), 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_frame(i % 2, 4'($urandom), 4'($urandom), $urandom_range(3), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
